// File: rtl/seq_multdiv_if.sv
// Operand/control/result bundle for seq_multdiv; the master drives start pulses and
// operands, and the slave returns the result.
interface seq_multdiv_if;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY
   );
   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY
   );
endinterface

// File: rtl/seq_multdiv.sv
// Sequential signed 32-bit Booth multiplier / non-restoring divider on one shared 33-bit adder.
// Divide datapath is present only when SEQ_MULTDIV_DIV_EN is defined.
module seq_multdiv (
   input  logic clock,
   input  logic reset,
   seq_multdiv_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [32:0] acc;        // Booth partial product P (sign-extended) or divide remainder
   logic [31:0] lo;         // multiplier / quotient shift register
   logic [31:0] opd;        // multiplicand or divisor magnitude
   logic        qm1;
   logic [31:0] res_q;
   logic        exc_q;
   logic [32:0] add_x, add_y, sum;
   logic        add_sub;
   logic        mul_exc;
   logic [32:0] hi_bits;

`ifdef SEQ_MULTDIV_DIV_EN
   logic        neg, dz;
   logic [31:0] a_mag, b_mag;
   assign a_mag = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
   assign b_mag = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;
`endif

   always_comb begin
      add_x   = acc;
      add_y   = {opd[31], opd};
      add_sub = 1'b0;
      if (state == MUL) begin
         case ({lo[0], qm1})
            2'b01:   add_sub = 1'b0;
            2'b10:   add_sub = 1'b1;
            default: add_y   = '0;
         endcase
      end
`ifdef SEQ_MULTDIV_DIV_EN
      else if (state == DIV) begin
         // shift remainder left pulling in next dividend bit; sign picks add vs subtract
         add_x   = {acc[31:0], lo[31]};
         add_y   = {1'b0, opd};
         add_sub = ~acc[32];
      end
`endif
   end

   assign sum = add_x + (add_y ^ {33{add_sub}}) + {32'd0, add_sub};

   // product fits signed 32 only if the upper 33 bits are all copies of one sign
   assign hi_bits = {acc[31:0], lo[31]};
   assign mul_exc = ~((&hi_bits) | ~(|hi_bits));

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         res_q <= '0;
         exc_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (bus.ctrl_MULT) begin
                  state <= MUL;
                  cnt   <= '0;
                  acc   <= '0;
                  lo    <= bus.data_operandB;
                  opd   <= bus.data_operandA;
                  qm1   <= 1'b0;
               end else if (bus.ctrl_DIV) begin
                  state <= DIV;
                  cnt   <= '0;
`ifdef SEQ_MULTDIV_DIV_EN
                  acc   <= '0;
                  lo    <= a_mag;
                  opd   <= b_mag;
                  neg   <= bus.data_operandA[31] ^ bus.data_operandB[31];
                  dz    <= (bus.data_operandB == 32'd0);
`endif
               end
            end
            MUL: begin
               if (cnt == 6'd32) begin
                  state <= DONE;
                  res_q <= lo;
                  exc_q <= mul_exc;
               end else begin
                  cnt <= cnt + 6'd1;
                  acc <= {sum[32], sum[32:1]};
                  lo  <= {sum[0], lo[31:1]};
                  qm1 <= lo[0];
               end
            end
            DIV: begin
`ifdef SEQ_MULTDIV_DIV_EN
               if (cnt == 6'd32) begin
                  state <= DONE;
                  if (dz) begin
                     res_q <= '0;
                     exc_q <= 1'b1;
                  end else begin
                     res_q <= neg ? (~lo + 32'd1) : lo;
                     exc_q <= ~neg & lo[31];
                  end
               end else begin
                  cnt <= cnt + 6'd1;
                  acc <= sum;
                  lo  <= {lo[30:0], ~sum[32]};
               end
`else
               state <= DONE;
               res_q <= '0;
               exc_q <= 1'b1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_result    = res_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = (state == DONE);
endmodule

// File: tb/tb_seq_multdiv.sv
// Self-checking bench for seq_multdiv: directed table, corner sequences, and random ops
// against an arithmetic reference model.
module tb_seq_multdiv;
`ifdef SEQ_MULTDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic clock;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;

   seq_multdiv_if bus();
   seq_multdiv dut (.clock(clock), .reset(reset), .bus(bus));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          m;
      bit          d;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] er;
      logic        ee;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint p;
      int     sa, sb;
      if (m) begin
         p = longint'(signed'(a)) * longint'(signed'(b));
         r = p[31:0];
         e = (p != longint'(signed'(p[31:0])));
      end else if (!DIV_EN) begin
         r = 32'd0; e = 1'b1;
      end else if (b == 32'd0) begin
         r = 32'd0; e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000; e = 1'b1;
      end else begin
         sa = a; sb = b;
         r = 32'(sa / sb);
         e = 1'b0;
      end
   endfunction

   // Called at a negedge; returns at the negedge of the RDY cycle.
   task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input int inj_k, input string nm);
      int          k, exp_lat;
      bit          got, stable;
      logic [31:0] prev;
      prev   = bus.data_result;
      stable = 1'b1;
      exp_lat = (!m && !DIV_EN) ? 1 : 33;
      bus.ctrl_MULT = m; bus.ctrl_DIV = d;
      bus.data_operandA = a; bus.data_operandB = b;
      @(posedge clock);
      @(negedge clock);
      bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
      bus.data_operandA = $urandom; bus.data_operandB = $urandom;
      k = 0; got = 1'b0;
      while (!got && k <= 60) begin
         if (k == inj_k) begin
            bus.ctrl_MULT = 1'b1; bus.ctrl_DIV = 1'b1;
            bus.data_operandA = $urandom; bus.data_operandB = $urandom;
         end else if (k == inj_k + 1) begin
            bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
         end
         if (bus.data_resultRDY) got = 1'b1;
         else begin
            if (bus.data_result !== prev) stable = 1'b0;
            @(negedge clock);
            k++;
         end
      end
      chk({nm, "_lat"}, 64'(k), 64'(exp_lat));
      chk({nm, "_res"}, 64'(bus.data_result), 64'(er));
      chk({nm, "_exc"}, 64'(bus.data_exception), 64'(ee));
      chk({nm, "_hold"}, 64'(stable), 64'd1);
   endtask

   vec_t        tbl[14];
   logic [31:0] er, ra, rb;
   logic        ee;
   bit          rm, rd;

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'd0;
         3: return 32'($urandom_range(0, 40)) - 32'd20;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      tbl[0]  = '{1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
      tbl[1]  = '{1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
      tbl[2]  = '{0, 1, 32'hFFFF_FFEF,  32'd5,         32'hFFFF_FFFD, 1'b0};
      tbl[3]  = '{0, 1, 32'd9,          32'd0,         32'h0000_0000, 1'b1};
      tbl[4]  = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      tbl[5]  = '{1, 1, 32'd6,          32'd7,         32'd42,        1'b0};
      tbl[6]  = '{1, 0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1};
      tbl[7]  = '{1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
      tbl[8]  = '{1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0};
      tbl[9]  = '{1, 0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1};
      tbl[10] = '{0, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
      tbl[11] = '{0, 1, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0};
      tbl[12] = '{0, 1, 32'd0,          32'd5,         32'd0,         1'b0};
      tbl[13] = '{1, 0, 32'd0,          32'd0,         32'd0,         1'b0};

      reset = 1'b0;
      bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
      bus.data_operandA = '0; bus.data_operandB = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_res", 64'(bus.data_result), 64'd0);
      chk("rst_exc", 64'(bus.data_exception), 64'd0);
      chk("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
      reset = 1'b1;

      foreach (tbl[i]) begin
         er = tbl[i].er; ee = tbl[i].ee;
         if (!tbl[i].m && !DIV_EN) begin er = 32'd0; ee = 1'b1; end
         do_op(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, er, ee, -1, $sformatf("tbl%0d", i));
         @(negedge clock);
         chk($sformatf("tbl%0d_pulse", i), 64'(bus.data_resultRDY), 64'd0);
      end

      // start pulses and operand changes mid-flight must be ignored
      model(1'b1, 32'd123, 32'hFFFF_FFD3, er, ee);
      do_op(1'b1, 1'b0, 32'd123, 32'hFFFF_FFD3, er, ee, 10, "ignore");
      @(negedge clock);

      // reset during a multiply: outputs clear, no strobe, then restart immediately
      do_op(1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0, -1, "pre_rst");
      bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd1000;
      @(posedge clock);
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      repeat (14) begin
         @(negedge clock);
      end
      reset = 1'b0;
      @(negedge clock);
      chk("abort_res", 64'(bus.data_result), 64'd0);
      chk("abort_exc", 64'(bus.data_exception), 64'd0);
      chk("abort_rdy", 64'(bus.data_resultRDY), 64'd0);
      reset = 1'b1;
      do_op(1'b1, 1'b0, 32'd2, 32'd3, 32'd6, 1'b0, -1, "post_rst");

      // random ops, often back-to-back off the DONE cycle
      for (int i = 0; i < 150; i++) begin
         rm = $urandom_range(0, 1);
         rd = rm ? ($urandom_range(0, 3) == 0) : 1'b1;
         ra = pick(); rb = pick();
         model(rm, ra, rb, er, ee);
         do_op(rm, rd, ra, rb, er, ee, -1, $sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 0) begin
            @(negedge clock);
            chk($sformatf("rnd%0d_pulse", i), 64'(bus.data_resultRDY), 64'd0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_multdiv.md
SEQ_MULTDIV -- requirements
Module: seq_multdiv

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset; sampled only on rising clock edge.
REQ-003 SHALL have port: data_operandA  input  32  signed two's-complement multiplicand / dividend.
REQ-004 SHALL have port: data_operandB  input  32  signed two's-complement multiplier / divisor.
REQ-005 SHALL have port: ctrl_MULT  input  1  one-cycle start pulse, multiply.
REQ-006 SHALL have port: ctrl_DIV  input  1  one-cycle start pulse, divide.
REQ-007 SHALL have port: data_result  output  32  low 32 bits of product, or quotient.
REQ-008 SHALL have port: data_exception  output  1  result not representable / divide-by-zero.
REQ-009 SHALL have port: data_resultRDY  output  1  one-cycle completion strobe.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-011 SHALL, in IDLE, on edge with ctrl_MULT=1 latch both operands, clear 6-bit counter, go to MUL.
REQ-012 SHALL, in IDLE, on edge with ctrl_DIV=1 and ctrl_MULT=0 latch operands, go to DIV; ctrl_MULT has priority when both are high.
REQ-013 SHALL ignore ctrl_MULT/ctrl_DIV in MUL, DIV, DONE (no restart, no queueing).
REQ-014 SHALL perform radix-2 Booth multiply, one add/sub + arithmetic shift of 65-bit {P, multiplier, q-1} per cycle, 32 iterations.
REQ-015 SHALL perform non-restoring divide on operand magnitudes, one add/sub + shift per cycle, 32 iterations; quotient sign = signA XOR signB, truncation toward zero.
REQ-016 SHALL use a single shared 33-bit add/sub datapath for both operations; per-step add overflow is internal, handled by 33-bit width.
REQ-017 SHALL enter DONE after counter reaches 32, assert data_resultRDY for exactly one cycle in DONE, then return to IDLE.
REQ-018 SHALL give latency: start sampled at edge N -> data_resultRDY high in the cycle following edge N+33.
REQ-019 SHALL allow a new start on the edge at which DONE exits (back-to-back ops: next RDY 34 cycles after previous RDY).
REQ-020 SHALL set multiply data_exception=1 when 64-bit product upper 33 bits are not all equal (result does not fit signed 32); data_result = low 32 bits regardless.
REQ-021 SHALL, for divide with data_operandB=0, give data_result=0, data_exception=1, with unchanged latency.
REQ-022 SHALL, for 0x80000000 / 0xFFFFFFFF, give data_result=0x80000000, data_exception=1.
REQ-023 SHALL hold data_result and data_exception stable from DONE until the next DONE; data_resultRDY=0 outside DONE.
REQ-024 SHALL compute the result only from latched operands; input changes after the start edge have no effect.

Reset
REQ-025 SHALL, on edge with reset=0, force state IDLE, counter 0, data_result=0, data_exception=0, data_resultRDY=0, regardless of state or start inputs.
REQ-026 SHALL abort any in-flight operation on reset with no RDY strobe for it; a start on the first edge with reset=1 is accepted.

Configuration
REQ-027 SHALL, with macro SEQ_MULTDIV_DIV_EN defined, implement divide per REQ-015, REQ-021, REQ-022.
REQ-028 SHALL, without SEQ_MULTDIV_DIV_EN, omit divide datapath; ctrl_DIV goes IDLE->DONE in one cycle, RDY high in the cycle following edge N+1, data_result=0, data_exception=1.

Verification
REQ-029 SHALL cover: MULT 7 x -3 -> after 33 cycles RDY pulse, result 0xFFFFFFEB, exception 0.
REQ-030 SHALL cover: MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-031 SHALL cover: DIV -17 / 5 -> result 0xFFFFFFFD, exception 0; DIV 9 / 0 -> result 0, exception 1, same latency.
REQ-032 SHALL cover: DIV 0x80000000 / -1 -> result 0x80000000, exception 1; both ctrl high with 6,7 -> result 42 (multiply).
REQ-033 SHALL cover: start MULT, pulse ctrl_DIV at cycle 10 and change operands -> ignored, product of original operands.
REQ-034 SHALL cover: reset=0 at cycle 15 of a MULT -> next edge all outputs 0, no RDY; new MULT 2 x 3 afterwards -> 6.
